// File: rtl/aixh_mxc_left_qtile_sched.sv
// aixh_mxc_left_qtile_sched: load/drain sequencer for one column of MxConv left queue-tile iscells.
// Define AIXH_MXC_LQSCHED_PERF_EN to add saturating full/empty stall counters.
`ifndef AIXH_LTC_MXC_RDATA_QDEPTH
`define AIXH_LTC_MXC_RDATA_QDEPTH 8
`endif
module aixh_mxc_left_qtile_sched #(
    parameter int SKEW_DEPTH = 1,
    parameter int QDEPTH = `AIXH_LTC_MXC_RDATA_QDEPTH,
    parameter int LEN_W = 8,
    parameter int RMODE_LAG = 2,
    localparam int LVL_W = $clog2(QDEPTH + 1)
) (
    input  logic             aixh_core_clk,
    input  logic             aixh_core_rst,
    input  logic             i_ld_valid,
    output logic             o_ld_ready,
    input  logic [LEN_W-1:0] i_ld_len,
    input  logic             i_src_valid,
    output logic             o_src_ready,
    input  logic             i_dr_valid,
    output logic             o_dr_ready,
    input  logic [LEN_W-1:0] i_dr_len,
    input  logic [1:0]       i_dr_rmode,
    output logic             o_senable,
    output logic             o_wenable,
    output logic             o_renable,
    output logic [1:0]       o_rmode,
    output logic             o_ld_done,
    output logic             o_dr_done,
`ifdef AIXH_MXC_LQSCHED_PERF_EN
    output logic [31:0]      o_full_stalls,
    output logic [31:0]      o_empty_stalls,
`endif
    output logic [LVL_W-1:0] o_level
);
    localparam logic [1:0] RMODE_KEEP = 2'd0;
    localparam logic [LVL_W-1:0] QFULL = LVL_W'(QDEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    typedef enum logic {LD_IDLE, LD_RUN} ld_state_t;
    typedef enum logic {DR_IDLE, DR_RUN} dr_state_t;
    ld_state_t ld_state, ld_nxt;
    dr_state_t dr_state, dr_nxt;
    logic [LEN_W-1:0] ld_cnt, dr_cnt;
    logic [1:0] dr_rmode_q, rmode_in;
    logic [LVL_W-1:0] rsv, level;
    logic ld_acc, dr_acc, ld_last, dr_last;
    always_comb begin
        ld_acc = i_ld_valid && o_ld_ready;
        dr_acc = i_dr_valid && o_dr_ready;
        o_senable = (ld_state == LD_RUN) && i_src_valid && (rsv < QFULL);
        o_src_ready = o_senable;
        ld_last = o_senable && (ld_cnt == LEN_ONE);
        o_renable = (dr_state == DR_RUN) && (level != '0);
        dr_last = o_renable && (dr_cnt == LEN_ONE);
        o_dr_done = dr_last;
        o_level = level;
        ld_nxt = ld_acc ? LD_RUN : ld_last ? LD_IDLE : ld_state;
        dr_nxt = dr_acc ? DR_RUN : dr_last ? DR_IDLE : dr_state;
        rmode_in = o_renable ? dr_rmode_q : RMODE_KEEP;
    end
    // len 0 wraps through all ones, giving 2**LEN_W beats before reaching 1
    always_ff @(posedge aixh_core_clk) begin
        if (aixh_core_rst) begin
            ld_state <= LD_IDLE;
            dr_state <= DR_IDLE;
            o_ld_ready <= 1'b0;
            o_dr_ready <= 1'b0;
            ld_cnt <= '0;
            dr_cnt <= '0;
            dr_rmode_q <= RMODE_KEEP;
            rsv <= '0;
            level <= '0;
        end else begin
            ld_state <= ld_nxt;
            dr_state <= dr_nxt;
            o_ld_ready <= ld_nxt == LD_IDLE;
            o_dr_ready <= dr_nxt == DR_IDLE;
            ld_cnt <= ld_acc ? i_ld_len : o_senable ? ld_cnt - 1'b1 : ld_cnt;
            dr_cnt <= dr_acc ? i_dr_len : o_renable ? dr_cnt - 1'b1 : dr_cnt;
            dr_rmode_q <= dr_acc ? i_dr_rmode : dr_rmode_q;
            rsv <= (o_senable && !o_renable) ? rsv + 1'b1 : (o_renable && !o_senable) ? rsv - 1'b1 : rsv;
            level <= (o_wenable && !o_renable) ? level + 1'b1 : (o_renable && !o_wenable) ? level - 1'b1 : level;
        end
    end
    // the last-beat flag travels with wenable so ld_done lands on the final write
    if (SKEW_DEPTH == 0) begin : g_wen_pass
        assign o_wenable = o_senable;
        assign o_ld_done = ld_last;
    end else begin : g_wen_dly
        logic [SKEW_DEPTH-1:0] wen_sr, last_sr;
        always_ff @(posedge aixh_core_clk) begin
            if (aixh_core_rst) begin
                wen_sr <= '0;
                last_sr <= '0;
            end else begin
                wen_sr <= SKEW_DEPTH'({wen_sr, o_senable});
                last_sr <= SKEW_DEPTH'({last_sr, ld_last});
            end
        end
        assign o_wenable = wen_sr[SKEW_DEPTH-1];
        assign o_ld_done = last_sr[SKEW_DEPTH-1];
    end
    if (RMODE_LAG == 0) begin : g_rm_pass
        assign o_rmode = rmode_in;
    end else begin : g_rm_dly
        logic [2*RMODE_LAG-1:0] rm_sr;
        always_ff @(posedge aixh_core_clk) begin
            if (aixh_core_rst) rm_sr <= {RMODE_LAG{RMODE_KEEP}};
            else rm_sr <= (2*RMODE_LAG)'({rm_sr, rmode_in});
        end
        assign o_rmode = rm_sr[2*RMODE_LAG-1 -: 2];
    end
`ifdef AIXH_MXC_LQSCHED_PERF_EN
    always_ff @(posedge aixh_core_clk) begin
        if (aixh_core_rst) begin
            o_full_stalls <= '0;
            o_empty_stalls <= '0;
        end else begin
            if (ld_state == LD_RUN && i_src_valid && rsv == QFULL && o_full_stalls != '1)
                o_full_stalls <= o_full_stalls + 32'd1;
            if (dr_state == DR_RUN && level == '0 && o_empty_stalls != '1)
                o_empty_stalls <= o_empty_stalls + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_aixh_mxc_left_qtile_sched.sv
// tb_aixh_mxc_left_qtile_sched: directed bench for the left qtile scheduler
// (SKEW_DEPTH=3, QDEPTH=8, LEN_W=2, RMODE_LAG=2).
module tb_aixh_mxc_left_qtile_sched;
    localparam logic [1:0] KEEP = 2'd0;
    localparam logic [1:0] DN_SHIFT = 2'd1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ld_valid = 1'b0, src_valid = 1'b1, dr_valid = 1'b0;
    logic [1:0] ld_len = '0, dr_len = '0, dr_rmode = '0;
    logic ld_ready, src_ready, dr_ready, sen, wen, ren, ld_done, dr_done;
    logic [1:0] rmode;
    logic [3:0] level;
`ifdef AIXH_MXC_LQSCHED_PERF_EN
    logic [31:0] full_stalls, empty_stalls;
`endif
    int cyc = 0, n_tests = 0, n_fail = 0;
    always #5 clk = ~clk;
    aixh_mxc_left_qtile_sched #(.SKEW_DEPTH(3), .QDEPTH(8), .LEN_W(2), .RMODE_LAG(2)) u_dut (
        .aixh_core_clk(clk), .aixh_core_rst(rst),
        .i_ld_valid(ld_valid), .o_ld_ready(ld_ready), .i_ld_len(ld_len),
        .i_src_valid(src_valid), .o_src_ready(src_ready),
        .i_dr_valid(dr_valid), .o_dr_ready(dr_ready), .i_dr_len(dr_len), .i_dr_rmode(dr_rmode),
        .o_senable(sen), .o_wenable(wen), .o_renable(ren), .o_rmode(rmode),
        .o_ld_done(ld_done), .o_dr_done(dr_done),
`ifdef AIXH_MXC_LQSCHED_PERF_EN
        .o_full_stalls(full_stalls), .o_empty_stalls(empty_stalls),
`endif
        .o_level(level)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
        dr_valid = 1'b0;
        cyc++;
    endtask
    task automatic go(input int n);
        repeat (n) tick();
    endtask
    task automatic drv_ld(input logic [1:0] len);
        chk("ld_ready", {31'd0, ld_ready}, 32'd1);
        ld_valid = 1'b1;
        ld_len = len;
    endtask
    task automatic drv_dr(input logic [1:0] len, input logic [1:0] rm);
        chk("dr_ready", {31'd0, dr_ready}, 32'd1);
        dr_valid = 1'b1;
        dr_len = len;
        dr_rmode = rm;
    endtask
    initial begin
        logic [7:0] e_sen, e_wen, e_done, e_ren;
        logic [11:0] e_ren3, e_dn3;
        // reset state
        tick();
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("rst_dr_ready", {31'd0, dr_ready}, 32'd0);
        chk("rst_sen", {31'd0, sen}, 32'd0);
        chk("rst_wen", {31'd0, wen}, 32'd0);
        chk("rst_ren", {31'd0, ren}, 32'd0);
        chk("rst_rmode", {30'd0, rmode}, {30'd0, KEEP});
        chk("rst_level", {28'd0, level}, 32'd0);
        rst = 1'b0;
        tick();
        // 1: len code 0 = 4 beats, wenable lags senable by 3
        drv_ld(2'd0);
        tick();
        e_sen = 8'h0F;
        e_wen = 8'h78;
        e_done = 8'h40;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t1_sen%0d", k), {31'd0, sen}, {31'd0, e_sen[k]});
            chk($sformatf("t1_wen%0d", k), {31'd0, wen}, {31'd0, e_wen[k]});
            chk($sformatf("t1_done%0d", k), {31'd0, ld_done}, {31'd0, e_done[k]});
            if (k == 7) chk("t1_level", {28'd0, level}, 32'd4);
            tick();
        end
        // 2: fill to 8, then a load stalls until a drain frees a slot
        drv_ld(2'd0);
        go(8);
        chk("t2_level_full", {28'd0, level}, 32'd8);
        drv_ld(2'd2);
        go(1);
        chk("t2_stall_a", {31'd0, sen}, 32'd0);
        go(3);
        chk("t2_stall_b", {31'd0, sen}, 32'd0);
        drv_dr(2'd1, KEEP);
        go(1);
        chk("t2_stall_c", {31'd0, sen}, 32'd0);
        chk("t2_ren", {31'd0, ren}, 32'd1);
        chk("t2_dr_done", {31'd0, dr_done}, 32'd1);
        go(1);
        chk("t2_sen_after_ren", {31'd0, sen}, 32'd1);
        chk("t2_src_ready", {31'd0, src_ready}, 32'd1);
`ifdef AIXH_MXC_LQSCHED_PERF_EN
        chk("t2_full_stalls", full_stalls, 32'd5);
`endif
        drv_dr(2'd1, KEEP);
        go(1);
        chk("t2_stall_d", {31'd0, sen}, 32'd0);
        chk("t2_ren2", {31'd0, ren}, 32'd1);
        go(1);
        chk("t2_sen_last", {31'd0, sen}, 32'd1);
        go(3);
        chk("t2_ld_done", {31'd0, ld_done}, 32'd1);
        chk("t2_wen_last", {31'd0, wen}, 32'd1);
        go(1);
        chk("t2_level_refill", {28'd0, level}, 32'd8);
        // empty the queue
        drv_dr(2'd0, KEEP);
        go(4);
        chk("t3_pre_ren", {31'd0, ren}, 32'd1);
        chk("t3_pre_done_a", {31'd0, dr_done}, 32'd1);
        go(1);
        drv_dr(2'd0, KEEP);
        go(4);
        chk("t3_pre_done_b", {31'd0, dr_done}, 32'd1);
        go(1);
        chk("t3_level_empty", {28'd0, level}, 32'd0);
        // 3: drain waits on empty, rmode follows renable by 2
        drv_dr(2'd3, DN_SHIFT);
        go(1);
        e_ren3 = 12'h1C0;
        e_dn3 = 12'h700;
        for (int k = 1; k < 12; k++) begin
            if (k == 1) drv_ld(2'd3);
            chk($sformatf("t3_ren%0d", k), {31'd0, ren}, {31'd0, e_ren3[k]});
            chk($sformatf("t3_rmode%0d", k), {30'd0, rmode}, {30'd0, e_dn3[k] ? DN_SHIFT : KEEP});
`ifdef AIXH_MXC_LQSCHED_PERF_EN
            if (k == 6) chk("t3_empty_stalls", empty_stalls, 32'd5);
`endif
            if (k == 7) chk("t3_ld_done", {31'd0, ld_done}, 32'd1);
            if (k == 8) chk("t3_dr_done", {31'd0, dr_done}, 32'd1);
            if (k == 9) chk("t3_level", {28'd0, level}, 32'd0);
            tick();
        end
        // 4: level 2, load and drain accepted together
        drv_ld(2'd2);
        go(6);
        chk("t4_level_start", {28'd0, level}, 32'd2);
        drv_ld(2'd3);
        drv_dr(2'd3, KEEP);
        e_ren = 8'h26;
        e_wen = 8'h70;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("t4_ren%0d", k), {31'd0, ren}, {31'd0, e_ren[k]});
            chk($sformatf("t4_wen%0d", k), {31'd0, wen}, {31'd0, e_wen[k]});
            chk($sformatf("t4_dr_done%0d", k), {31'd0, dr_done}, {31'd0, k == 5});
            chk($sformatf("t4_ld_done%0d", k), {31'd0, ld_done}, {31'd0, k == 6});
            if (k == 6) chk("t4_level6", {28'd0, level}, 32'd1);
            if (k == 7) chk("t4_level7", {28'd0, level}, 32'd2);
        end
        tick();
        // 5: reset in the middle of a 4-beat burst
        drv_ld(2'd0);
        go(1);
        chk("t5_sen", {31'd0, sen}, 32'd1);
        go(1);
        rst = 1'b1;
        go(1);
        chk("t5_rst_sen", {31'd0, sen}, 32'd0);
        chk("t5_rst_wen", {31'd0, wen}, 32'd0);
        chk("t5_rst_ren", {31'd0, ren}, 32'd0);
        chk("t5_rst_level", {28'd0, level}, 32'd0);
        chk("t5_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        chk("t5_rst_dr_ready", {31'd0, dr_ready}, 32'd0);
        chk("t5_rst_rmode", {30'd0, rmode}, {30'd0, KEEP});
        chk("t5_rst_done", {30'd0, ld_done, dr_done}, 32'd0);
`ifdef AIXH_MXC_LQSCHED_PERF_EN
        chk("t5_rst_full_stalls", full_stalls, 32'd0);
        chk("t5_rst_empty_stalls", empty_stalls, 32'd0);
`endif
        rst = 1'b0;
        go(1);
        drv_ld(2'd1);
        for (int k = 4; k < 8; k++) begin
            chk($sformatf("t5_wen%0d", k), {31'd0, wen}, 32'd0);
            chk($sformatf("t5_ld_done%0d", k), {31'd0, ld_done}, 32'd0);
            if (k == 5) chk("t5_new_sen", {31'd0, sen}, 32'd1);
            tick();
        end
        chk("t5_new_wen", {31'd0, wen}, 32'd1);
        chk("t5_new_done", {31'd0, ld_done}, 32'd1);
        go(1);
        chk("t5_new_level", {28'd0, level}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
